// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the new_alu datapath: MODE encodings, opcode values
// for both command sets, INP_VALID encodings and the operand-need type used
// to decide whether the operands an operation needs are actually present.
// Optional build macro: ALU_SIGNED_EN (adds the signed SADD/SSUB opcodes in
// arithmetic mode; the opcode values are always defined here).
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic MODE_ARITH = 1'b1;
   localparam logic MODE_LOGIC = 1'b0;

   // Arithmetic command set (MODE = 1)
   localparam logic [3:0] CMD_ADD     = 4'd0;
   localparam logic [3:0] CMD_SUB     = 4'd1;
   localparam logic [3:0] CMD_ADD_CIN = 4'd2;
   localparam logic [3:0] CMD_SUB_CIN = 4'd3;
   localparam logic [3:0] CMD_INC_A   = 4'd4;
   localparam logic [3:0] CMD_DEC_A   = 4'd5;
   localparam logic [3:0] CMD_INC_B   = 4'd6;
   localparam logic [3:0] CMD_DEC_B   = 4'd7;
   localparam logic [3:0] CMD_CMP     = 4'd8;
   localparam logic [3:0] CMD_SADD    = 4'd11;
   localparam logic [3:0] CMD_SSUB    = 4'd12;

   // Logical command set (MODE = 0)
   localparam logic [3:0] CMD_AND     = 4'd0;
   localparam logic [3:0] CMD_NAND    = 4'd1;
   localparam logic [3:0] CMD_OR      = 4'd2;
   localparam logic [3:0] CMD_NOR     = 4'd3;
   localparam logic [3:0] CMD_XOR     = 4'd4;
   localparam logic [3:0] CMD_XNOR    = 4'd5;
   localparam logic [3:0] CMD_NOT_A   = 4'd6;
   localparam logic [3:0] CMD_NOT_B   = 4'd7;
   localparam logic [3:0] CMD_SHR_A   = 4'd8;
   localparam logic [3:0] CMD_SHL_A   = 4'd9;
   localparam logic [3:0] CMD_SHR_B   = 4'd10;
   localparam logic [3:0] CMD_SHL_B   = 4'd11;
   localparam logic [3:0] CMD_ROL_A   = 4'd12;
   localparam logic [3:0] CMD_ROR_A   = 4'd13;

   // INP_VALID encodings: bit0 = OPA valid, bit1 = OPB valid
   localparam logic [1:0] IV_NONE = 2'b00;
   localparam logic [1:0] IV_A    = 2'b01;
   localparam logic [1:0] IV_B    = 2'b10;
   localparam logic [1:0] IV_BOTH = 2'b11;

   // Which operands an operation consumes; the encoding lines up with
   // INP_VALID so a simple mask test tells whether they are all present.
   typedef enum logic [1:0] {
      NEED_A  = 2'b01,
      NEED_B  = 2'b10,
      NEED_AB = 2'b11
   } operand_need_e;

   // True when every operand in 'need' is flagged valid. INP_VALID = 00 can
   // never satisfy any need, so it always turns into an error upstream.
   function automatic logic operandsOk(input operand_need_e need, input logic [1:0] inpValid);
      logic [1:0] needBits;
      needBits = need;
      return (inpValid != IV_NONE) && ((inpValid & needBits) == needBits);
   endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// ---------------------------------------------------------------------------
// alu_logic_unit
// Purely combinational evaluator for the logical (MODE = 0) command set:
// bitwise ops, single-bit shifts and rotates of A by OPB's low bits.
// Ports:
//   opa_i, opb_i    operands
//   cmd_i           logical opcode
//   res_o           WIDTH-bit result (the top adds the zero MSB)
//   rotErr_o        rotate requested with OPB upper bits non-zero
//   illegal_o       opcode has no logical meaning
//   need_o          operands this opcode consumes
// Optional build macro: none (ALU_SIGNED_EN only affects the top).
// ---------------------------------------------------------------------------
module alu_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CMD_W = 4
) (
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   input  logic [CMD_W-1:0] cmd_i,
   output logic [WIDTH-1:0] res_o,
   output logic             rotErr_o,
   output logic             illegal_o,
   output operand_need_e    need_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]     rotAmt;
   logic [2*WIDTH-1:0] rolFull;
   logic [2*WIDTH-1:0] rorFull;
   logic               rotUpperSet;

   // Rotates are done by shifting a doubled copy of A: the bits that fall
   // off one end reappear from the other copy, so no wrap logic is needed.
   always_comb begin
      rotAmt      = opb_i[SHW-1:0];
      rolFull     = {opa_i, opa_i} << rotAmt;
      rorFull     = {opa_i, opa_i} >> rotAmt;
      rotUpperSet = |opb_i[WIDTH-1:SHW+1];
   end

   // Opcode decode. Every path starts from "legal, needs both, result 0"
   // and each case only overrides what differs.
   always_comb begin
      res_o     = '0;
      rotErr_o  = 1'b0;
      illegal_o = 1'b0;
      need_o    = NEED_AB;
      case (cmd_i)
         CMD_AND:   res_o = opa_i & opb_i;
         CMD_NAND:  res_o = ~(opa_i & opb_i);
         CMD_OR:    res_o = opa_i | opb_i;
         CMD_NOR:   res_o = ~(opa_i | opb_i);
         CMD_XOR:   res_o = opa_i ^ opb_i;
         CMD_XNOR:  res_o = ~(opa_i ^ opb_i);
         CMD_NOT_A: begin
            res_o  = ~opa_i;
            need_o = NEED_A;
         end
         CMD_NOT_B: begin
            res_o  = ~opb_i;
            need_o = NEED_B;
         end
         CMD_SHR_A: begin
            res_o  = opa_i >> 1;
            need_o = NEED_A;
         end
         CMD_SHL_A: begin
            res_o  = opa_i << 1;
            need_o = NEED_A;
         end
         CMD_SHR_B: begin
            res_o  = opb_i >> 1;
            need_o = NEED_B;
         end
         CMD_SHL_B: begin
            res_o  = opb_i << 1;
            need_o = NEED_B;
         end
         CMD_ROL_A: begin
            res_o    = rolFull[2*WIDTH-1:WIDTH];
            rotErr_o = rotUpperSet;
         end
         CMD_ROR_A: begin
            res_o    = rorFull[WIDTH-1:0];
            rotErr_o = rotUpperSet;
         end
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/new_alu.sv
// ---------------------------------------------------------------------------
// new_alu
// Registered 8-bit ALU. Inputs are sampled on a rising clk edge with CE=1
// and the registered outputs change on that same edge. MODE picks the
// arithmetic (1) or logical (0) command set, CMD the operation.
// Ports:
//   clk, rst        clock (rising) and asynchronous active-high reset
//   CE              clock enable; outputs hold while low
//   INP_VALID       bit0 = OPA valid, bit1 = OPB valid
//   MODE, CMD       operation select
//   OPA, OPB, CIN   operands and carry in (CIN used by ADD_CIN/SUB_CIN only)
//   RES             WIDTH+1 bit result
//   COUT, OFLOW     carry out, overflow/borrow
//   G, E, L         compare flags
//   ERR             illegal command or missing operand
// Optional build macro: ALU_SIGNED_EN enables arithmetic CMD11 (SADD) and
// CMD12 (SSUB); without it those opcodes report ERR.
// ---------------------------------------------------------------------------
module new_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CMD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             CE,
   input  logic [1:0]       INP_VALID,
   input  logic             MODE,
   input  logic [CMD_W-1:0] CMD,
   input  logic [WIDTH-1:0] OPA,
   input  logic [WIDTH-1:0] OPB,
   input  logic             CIN,
   output logic [WIDTH:0]   RES,
   output logic             COUT,
   output logic             OFLOW,
   output logic             G,
   output logic             E,
   output logic             L,
   output logic             ERR
);

   localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

   logic [WIDTH:0]   aExt;
   logic [WIDTH:0]   bExt;
   logic [WIDTH:0]   cinExt;
   logic [WIDTH:0]   sumAB;
   logic [WIDTH:0]   sumABC;
   logic [WIDTH:0]   diffAB;
   logic [WIDTH:0]   diffABC;
   logic [WIDTH:0]   bPlusCin;
`ifdef ALU_SIGNED_EN
   logic [WIDTH:0]   aSext;
   logic [WIDTH:0]   bSext;
   logic [WIDTH:0]   sSum;
   logic [WIDTH:0]   sDiff;
   logic             sGt;
   logic             sLt;
`endif

   logic [WIDTH:0]   arithRes;
   logic             arithCout;
   logic             arithOflow;
   logic             arithG;
   logic             arithE;
   logic             arithL;
   logic             arithIllegal;
   operand_need_e    arithNeed;

   logic [WIDTH-1:0] logicRes;
   logic             logicRotErr;
   logic             logicIllegal;
   operand_need_e    logicNeed;

   logic [WIDTH:0]   res_d, res_q;
   logic             cout_d, cout_q;
   logic             oflow_d, oflow_q;
   logic             g_d, g_q;
   logic             e_d, e_q;
   logic             l_d, l_q;
   logic             err_d, err_q;

   // The logical command set lives in its own combinational block.
   alu_logic_unit #(
      .WIDTH (WIDTH),
      .CMD_W (CMD_W)
   ) u_logic (
      .opa_i     (OPA),
      .opb_i     (OPB),
      .cmd_i     (CMD),
      .res_o     (logicRes),
      .rotErr_o  (logicRotErr),
      .illegal_o (logicIllegal),
      .need_o    (logicNeed)
   );

   // All arithmetic is carried out one bit wider than the operands so the
   // MSB of a sum is the carry and a subtract wraps modulo 2^(WIDTH+1).
   // B+CIN cannot overflow the wide form, so the SUB_CIN borrow is a plain
   // unsigned compare against it.
   always_comb begin
      aExt     = {1'b0, OPA};
      bExt     = {1'b0, OPB};
      cinExt   = {{WIDTH{1'b0}}, CIN};
      sumAB    = aExt + bExt;
      sumABC   = aExt + bExt + cinExt;
      diffAB   = aExt - bExt;
      diffABC  = aExt - bExt - cinExt;
      bPlusCin = bExt + cinExt;
   end

`ifdef ALU_SIGNED_EN
   // Signed ops sign-extend both operands so RES carries the true sum or
   // difference; overflow is judged on the WIDTH-bit two's complement result.
   always_comb begin
      aSext = {OPA[WIDTH-1], OPA};
      bSext = {OPB[WIDTH-1], OPB};
      sSum  = aSext + bSext;
      sDiff = aSext - bSext;
      sGt   = $signed(OPA) > $signed(OPB);
      sLt   = $signed(OPA) < $signed(OPB);
   end
`endif

   // Arithmetic opcode decode. Flags that an operation does not define
   // stay at their zero default.
   always_comb begin
      arithRes     = '0;
      arithCout    = 1'b0;
      arithOflow   = 1'b0;
      arithG       = 1'b0;
      arithE       = 1'b0;
      arithL       = 1'b0;
      arithIllegal = 1'b0;
      arithNeed    = NEED_AB;
      case (CMD)
         CMD_ADD: begin
            arithRes  = sumAB;
            arithCout = sumAB[WIDTH];
         end
         CMD_SUB: begin
            arithRes   = diffAB;
            arithOflow = aExt < bExt;
         end
         CMD_ADD_CIN: begin
            arithRes  = sumABC;
            arithCout = sumABC[WIDTH];
         end
         CMD_SUB_CIN: begin
            arithRes   = diffABC;
            arithOflow = aExt < bPlusCin;
         end
         CMD_INC_A: begin
            arithRes  = aExt + ONE_EXT;
            arithNeed = NEED_A;
         end
         CMD_DEC_A: begin
            arithRes  = aExt - ONE_EXT;
            arithNeed = NEED_A;
         end
         CMD_INC_B: begin
            arithRes  = bExt + ONE_EXT;
            arithNeed = NEED_B;
         end
         CMD_DEC_B: begin
            arithRes  = bExt - ONE_EXT;
            arithNeed = NEED_B;
         end
         CMD_CMP: begin
            arithG = OPA > OPB;
            arithE = OPA == OPB;
            arithL = OPA < OPB;
         end
`ifdef ALU_SIGNED_EN
         CMD_SADD: begin
            arithRes   = sSum;
            arithOflow = (OPA[WIDTH-1] == OPB[WIDTH-1]) && (sSum[WIDTH-1] != OPA[WIDTH-1]);
            arithG     = sGt;
            arithE     = OPA == OPB;
            arithL     = sLt;
         end
         CMD_SSUB: begin
            arithRes   = sDiff;
            arithOflow = (OPA[WIDTH-1] != OPB[WIDTH-1]) && (sDiff[WIDTH-1] != OPA[WIDTH-1]);
            arithG     = sGt;
            arithE     = OPA == OPB;
            arithL     = sLt;
         end
`endif
         default:  arithIllegal = 1'b1;
      endcase
   end

   // Select the active command set and apply the error rules. An illegal
   // opcode or a missing operand forces everything except ERR to zero. A
   // rotate with stray OPB upper bits is the one error that keeps its
   // result, because the rotation itself is still well defined.
   always_comb begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      g_d     = 1'b0;
      e_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b0;
      if (MODE == MODE_ARITH) begin
         if (arithIllegal || !operandsOk(arithNeed, INP_VALID)) begin
            err_d = 1'b1;
         end else begin
            res_d   = arithRes;
            cout_d  = arithCout;
            oflow_d = arithOflow;
            g_d     = arithG;
            e_d     = arithE;
            l_d     = arithL;
         end
      end else begin
         if (logicIllegal || !operandsOk(logicNeed, INP_VALID)) begin
            err_d = 1'b1;
         end else begin
            res_d = {1'b0, logicRes};
            err_d = logicRotErr;
         end
      end
   end

   // Output registers: cleared asynchronously by reset, rewritten in full
   // on every enabled edge, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         cout_q  <= 1'b0;
         oflow_q <= 1'b0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         l_q     <= 1'b0;
         err_q   <= 1'b0;
      end else if (CE) begin
         res_q   <= res_d;
         cout_q  <= cout_d;
         oflow_q <= oflow_d;
         g_q     <= g_d;
         e_q     <= e_d;
         l_q     <= l_d;
         err_q   <= err_d;
      end
   end

   assign RES   = res_q;
   assign COUT  = cout_q;
   assign OFLOW = oflow_q;
   assign G     = g_q;
   assign E     = e_q;
   assign L     = l_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_new_alu.sv
// ---------------------------------------------------------------------------
// tb_new_alu
// Directed self-checking bench for new_alu. Each step drives one operation
// and pushes the hand-derived expected outputs to a scoreboard queue; the
// entry is popped and compared once the registered result is visible.
// ---------------------------------------------------------------------------
module tb_new_alu;
   import alu_pkg::*;

   typedef struct {
      logic [8:0] res;
      logic       cout;
      logic       oflow;
      logic       g;
      logic       e;
      logic       l;
      logic       err;
      bit         chkRes;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       CE;
   logic [1:0] INP_VALID;
   logic       MODE;
   logic [3:0] CMD;
   logic [7:0] OPA;
   logic [7:0] OPB;
   logic       CIN;
   logic [8:0] RES;
   logic       COUT;
   logic       OFLOW;
   logic       G;
   logic       E;
   logic       L;
   logic       ERR;

   exp_t scoreboard[$];
   int   errors = 0;
   int   checks = 0;

   new_alu #(.WIDTH(8), .CMD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .CE        (CE),
      .INP_VALID (INP_VALID),
      .MODE      (MODE),
      .CMD       (CMD),
      .OPA       (OPA),
      .OPB       (OPB),
      .CIN       (CIN),
      .RES       (RES),
      .COUT      (COUT),
      .OFLOW     (OFLOW),
      .G         (G),
      .E         (E),
      .L         (L),
      .ERR       (ERR)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Safety net so a broken build can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Build an expected-output record
   function automatic exp_t mkExp(input string tag, input logic [8:0] res, input logic cout,
                                  input logic oflow, input logic g, input logic e, input logic l,
                                  input logic err, input bit chkRes = 1'b1);
      exp_t x;
      x.tag    = tag;
      x.res    = res;
      x.cout   = cout;
      x.oflow  = oflow;
      x.g      = g;
      x.e      = e;
      x.l      = l;
      x.err    = err;
      x.chkRes = chkRes;
      return x;
   endfunction

   // One counted comparison of a DUT output against its expected value
   task automatic checkField(input string tag, input string field, input logic [8:0] observed,
                             input logic [8:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
      end
   endtask

   // Pop the oldest expectation and compare every output against it
   task automatic checkOutput();
      exp_t x;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard observed=empty expected=entry");
      end else begin
         x = scoreboard.pop_front();
         if (x.chkRes) checkField(x.tag, "RES", RES, x.res);
         checkField(x.tag, "COUT",  9'(COUT),  9'(x.cout));
         checkField(x.tag, "OFLOW", 9'(OFLOW), 9'(x.oflow));
         checkField(x.tag, "G",     9'(G),     9'(x.g));
         checkField(x.tag, "E",     9'(E),     9'(x.e));
         checkField(x.tag, "L",     9'(L),     9'(x.l));
         checkField(x.tag, "ERR",   9'(ERR),   9'(x.err));
      end
   endtask

   // Drive one operation on the falling edge, record its expectation, and
   // check just after the rising edge that registers it.
   task automatic applyStimulus(input logic ce, input logic [1:0] iv, input logic mode,
                                input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input exp_t x);
      @(negedge clk);
      CE        = ce;
      INP_VALID = iv;
      MODE      = mode;
      CMD       = cmd;
      OPA       = a;
      OPB       = b;
      CIN       = cin;
      scoreboard.push_back(x);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Every output must read zero
   task automatic checkAllZero(input string tag);
      checkField(tag, "RES",   RES,       9'h000);
      checkField(tag, "COUT",  9'(COUT),  9'h000);
      checkField(tag, "OFLOW", 9'(OFLOW), 9'h000);
      checkField(tag, "G",     9'(G),     9'h000);
      checkField(tag, "E",     9'(E),     9'h000);
      checkField(tag, "L",     9'(L),     9'h000);
      checkField(tag, "ERR",   9'(ERR),   9'h000);
   endtask

   initial begin
      rst       = 1'b1;
      CE        = 1'b0;
      INP_VALID = IV_NONE;
      MODE      = MODE_LOGIC;
      CMD       = 4'd0;
      OPA       = 8'h00;
      OPB       = 8'h00;
      CIN       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Clock enable low: nothing updates after reset
      applyStimulus(1'b0, IV_BOTH, MODE_ARITH, CMD_ADD, 8'h01, 8'h01, 1'b0,
                    mkExp("ce_idle", 9'h000, 0, 0, 0, 0, 0, 0));

      // Arithmetic set
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_ADD, 8'hFF, 8'h01, 1'b0,
                    mkExp("add_ovf", 9'h100, 1, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_ADD, 8'h01, 8'h01, 1'b1,
                    mkExp("add_cin_ignored", 9'h002, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_ADD_CIN, 8'hFF, 8'hFF, 1'b1,
                    mkExp("add_cin", 9'h1FF, 1, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SUB, 8'h05, 8'h0A, 1'b0,
                    mkExp("sub_borrow", 9'h1FB, 0, 1, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SUB, 8'h0A, 8'h05, 1'b1,
                    mkExp("sub_plain", 9'h005, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SUB_CIN, 8'h0A, 8'h05, 1'b1,
                    mkExp("sub_cin", 9'h004, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SUB_CIN, 8'h05, 8'h05, 1'b1,
                    mkExp("sub_cin_borrow", 9'h1FF, 0, 1, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_CMP, 8'h0A, 8'h0A, 1'b0,
                    mkExp("cmp_eq", 9'h000, 0, 0, 0, 1, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_CMP, 8'h0B, 8'h0A, 1'b0,
                    mkExp("cmp_gt", 9'h000, 0, 0, 1, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_CMP, 8'h03, 8'hF0, 1'b0,
                    mkExp("cmp_lt", 9'h000, 0, 0, 0, 0, 1, 0));
      applyStimulus(1'b1, IV_B, MODE_ARITH, CMD_INC_A, 8'h10, 8'h00, 1'b0,
                    mkExp("inc_a_missing", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_A, MODE_ARITH, CMD_INC_A, 8'h10, 8'h00, 1'b0,
                    mkExp("inc_a", 9'h011, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_A, MODE_ARITH, CMD_DEC_A, 8'h00, 8'h33, 1'b0,
                    mkExp("dec_a_wrap", 9'h1FF, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_B, MODE_ARITH, CMD_INC_B, 8'h00, 8'hFF, 1'b0,
                    mkExp("inc_b", 9'h100, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_B, MODE_ARITH, CMD_DEC_B, 8'h77, 8'h05, 1'b0,
                    mkExp("dec_b", 9'h004, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b0, IV_BOTH, MODE_ARITH, CMD_ADD, 8'h01, 8'h01, 1'b0,
                    mkExp("ce_hold", 9'h004, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SUB, 8'h01, 8'h02, 1'b0,
                    mkExp("sub_one_below", 9'h1FF, 0, 1, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_NONE, MODE_ARITH, CMD_ADD, 8'h01, 8'h01, 1'b0,
                    mkExp("iv_none", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, 4'd9, 8'h01, 8'h01, 1'b0,
                    mkExp("arith_cmd9", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, 4'd13, 8'h01, 8'h01, 1'b0,
                    mkExp("arith_cmd13", 9'h000, 0, 0, 0, 0, 0, 1));

      // Logical set
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_AND, 8'hAA, 8'h0F, 1'b1,
                    mkExp("and", 9'h00A, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_NAND, 8'hAA, 8'h0F, 1'b0,
                    mkExp("nand", 9'h0F5, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_OR, 8'hAA, 8'h0F, 1'b0,
                    mkExp("or", 9'h0AF, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_NOR, 8'hAA, 8'h0F, 1'b0,
                    mkExp("nor", 9'h050, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_XOR, 8'hAA, 8'h0F, 1'b0,
                    mkExp("xor", 9'h0A5, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_XNOR, 8'hAA, 8'h0F, 1'b0,
                    mkExp("xnor", 9'h05A, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_A, MODE_LOGIC, CMD_NOT_A, 8'hAA, 8'h0F, 1'b0,
                    mkExp("not_a", 9'h055, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_B, MODE_LOGIC, CMD_NOT_A, 8'hAA, 8'h0F, 1'b0,
                    mkExp("not_a_missing", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_B, MODE_LOGIC, CMD_NOT_B, 8'hAA, 8'h0F, 1'b0,
                    mkExp("not_b", 9'h0F0, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_A, MODE_LOGIC, CMD_SHR_A, 8'h81, 8'h00, 1'b0,
                    mkExp("shr_a", 9'h040, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_A, MODE_LOGIC, CMD_SHL_A, 8'h81, 8'h00, 1'b0,
                    mkExp("shl_a", 9'h002, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_B, MODE_LOGIC, CMD_SHR_B, 8'h00, 8'h81, 1'b0,
                    mkExp("shr_b", 9'h040, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_B, MODE_LOGIC, CMD_SHL_B, 8'h00, 8'hC3, 1'b0,
                    mkExp("shl_b", 9'h086, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_ROL_A, 8'h81, 8'h01, 1'b0,
                    mkExp("rol1", 9'h003, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_ROL_A, 8'h96, 8'h03, 1'b0,
                    mkExp("rol3", 9'h0B4, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_ROR_A, 8'h81, 8'h01, 1'b0,
                    mkExp("ror1", 9'h0C0, 0, 0, 0, 0, 0, 0));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_ROL_A, 8'h81, 8'h10, 1'b0,
                    mkExp("rol_bad_opb", 9'h081, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, CMD_ROR_A, 8'h81, 8'h82, 1'b0,
                    mkExp("ror_bad_opb", 9'h060, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, 4'd14, 8'h81, 8'h01, 1'b0,
                    mkExp("logic_cmd14", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_LOGIC, 4'd15, 8'h81, 8'h01, 1'b0,
                    mkExp("logic_cmd15", 9'h000, 0, 0, 0, 0, 0, 1));

      // Signed extension
`ifdef ALU_SIGNED_EN
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SADD, 8'h7F, 8'h01, 1'b0,
                    mkExp("sadd_ovf", 9'h000, 0, 1, 1, 0, 0, 0, 1'b0));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SSUB, 8'h80, 8'h01, 1'b0,
                    mkExp("ssub_ovf", 9'h000, 0, 1, 0, 0, 1, 0, 1'b0));
`else
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SADD, 8'h7F, 8'h01, 1'b0,
                    mkExp("sadd_off", 9'h000, 0, 0, 0, 0, 0, 1));
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_SSUB, 8'h80, 8'h01, 1'b0,
                    mkExp("ssub_off", 9'h000, 0, 0, 0, 0, 0, 1));
`endif

      // Mid-operation reset: load a non-zero result, then reset between edges
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_ADD, 8'hF0, 8'h20, 1'b0,
                    mkExp("pre_reset", 9'h110, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      CE        = 1'b1;
      INP_VALID = IV_BOTH;
      MODE      = MODE_ARITH;
      CMD       = CMD_ADD;
      OPA       = 8'hF0;
      OPB       = 8'h20;
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("async_reset");
      @(posedge clk);
      #1;
      checkAllZero("reset_held");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, IV_BOTH, MODE_ARITH, CMD_ADD, 8'h02, 8'h03, 1'b0,
                    mkExp("post_reset", 9'h005, 0, 0, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
